y86_regfile_sb: RTL and testbench

- Parametrised successor to the single-cycle Y86-64 register file, built for the pipelined core.
- Provides two combinational read ports (srcA, srcB) with same-cycle write-through bypass.
- Provides two clocked write ports: E (ALU result) and M (memory result).
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards and stall issue; sits between decode (read/issue) and writeback.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/y86_pend_sb.sv | 80 ++++++++
 rtl/y86_regfile_sb.sv | 86 ++++++++
 tb/tb_y86_regfile_sb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register-index encodings, instruction codes and the
// register-index type used across the pipelined core.
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/y86_pend_sb.sv
// Per-register pending-write scoreboard: counts issued-but-not-written-back
// destinations so decode can see RAW hazards and stall before a counter overflows.
module y86_pend_sb #(
    parameter int NREGS  = 15,
    parameter int IDX_W  = 4,
    parameter int PEND_W = 2
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_srcA,
    input  logic [IDX_W-1:0] i_srcB,
    input  logic             i_iss_valid,
    input  logic [IDX_W-1:0] i_iss_dstE,
    input  logic [IDX_W-1:0] i_iss_dstM,
    input  logic [IDX_W-1:0] i_dstE,
    input  logic [IDX_W-1:0] i_dstM,
    output logic             o_iss_ready,
    output logic             o_okA,
    output logic             o_okB
);

    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] r_pend [NREGS];
    logic [NREGS-1:0]  w_hit;
    logic [NREGS-1:0]  w_dec;
    logic [NREGS-1:0]  w_full;
    logic [NREGS-1:0]  w_zero;
    logic [NREGS-1:0]  w_inc;

    // Indices at or beyond NREGS (RNONE included) never match a counter, so they
    // neither count nor block issue.
    always_comb begin
        w_hit  = '0;
        w_dec  = '0;
        w_full = '0;
        w_zero = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_hit[r]  = i_iss_valid && (i_iss_dstE == IDX_W'(r) || i_iss_dstM == IDX_W'(r));
            w_dec[r]  = (i_dstE == IDX_W'(r)) || (i_dstM == IDX_W'(r));
            w_full[r] = (r_pend[r] == PEND_MAX);
            w_zero[r] = (r_pend[r] == '0);
        end
    end

    // Issue handshake: an issue is accepted only in a cycle where i_iss_valid and
    // o_iss_ready are both high; o_iss_ready looks combinationally at the issuing
    // destinations and this cycle's writebacks, so a full counter that drains now
    // can still take a new issue.
    assign o_iss_ready = ~|(w_hit & w_full & ~w_dec);
    assign w_inc       = w_hit & {NREGS{o_iss_ready}};

    always_comb begin
        o_okA = 1'b1;
        o_okB = 1'b1;
        if (int'(i_srcA) < NREGS)
            o_okA = (r_pend[i_srcA] == '0) || (r_pend[i_srcA] == PEND_ONE && w_dec[i_srcA]);
        if (int'(i_srcB) < NREGS)
            o_okB = (r_pend[i_srcB] == '0) || (r_pend[i_srcB] == PEND_ONE && w_dec[i_srcB]);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREGS; r++) r_pend[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r])
                    r_pend[r] <= r_pend[r] + PEND_ONE;
                else if (w_dec[r] && !w_inc[r] && !w_zero[r])
                    r_pend[r] <= r_pend[r] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) assert (!(|(w_dec & w_zero))) else $error("pending counter underflow");
    end

endmodule

// File: rtl/y86_regfile_sb.sv
// Pipelined Y86-64 register file: two bypassed read ports, E/M write ports with
// M-over-E priority, and a pending-write scoreboard for RAW hazard stalls.
module y86_regfile_sb
    import y86_pkg::*;
#(
    parameter int                 DATA_W  = 64,
    parameter int                 NREGS   = 15,
    parameter int                 IDX_W   = 4,
    parameter int                 PEND_W  = 2,
    parameter int                 SP_IDX  = int'(RSP),
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(64'h0000_0000_0000_FFF8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  srcA,
    input  logic [IDX_W-1:0]  srcB,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic              rdyA,
    output logic              rdyB,
    input  logic              iss_valid,
    input  logic [IDX_W-1:0]  iss_dstE,
    input  logic [IDX_W-1:0]  iss_dstM,
    output logic              iss_ready,
    input  logic [IDX_W-1:0]  dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [IDX_W-1:0]  dstM,
    input  logic [DATA_W-1:0] valM
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              w_okA;
    logic              w_okB;

    y86_pend_sb #(
        .NREGS  (NREGS),
        .IDX_W  (IDX_W),
        .PEND_W (PEND_W)
    ) u_pend (
        .clk         (clk),
        .i_rst       (rst),
        .i_srcA      (srcA),
        .i_srcB      (srcB),
        .i_iss_valid (iss_valid),
        .i_iss_dstE  (iss_dstE),
        .i_iss_dstM  (iss_dstM),
        .i_dstE      (dstE),
        .i_dstM      (dstM),
        .o_iss_ready (iss_ready),
        .o_okA       (w_okA),
        .o_okB       (w_okB)
    );

    assign rdyA = w_okA;
    assign rdyB = w_okB;

    // The M write follows the E write so it wins on dstE == dstM (popq %rsp).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                r_regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
        end else begin
            if (int'(dstE) < NREGS) r_regs[dstE] <= valE;
            if (int'(dstM) < NREGS) r_regs[dstM] <= valM;
        end
    end

    always_comb begin
        valA = '0;
        if (int'(srcA) < NREGS) begin
            if (srcA == dstM)      valA = valM;
            else if (srcA == dstE) valA = valE;
            else                   valA = r_regs[srcA];
        end
    end

    always_comb begin
        valB = '0;
        if (int'(srcB) < NREGS) begin
            if (srcB == dstM)      valB = valM;
            else if (srcB == dstE) valB = valE;
            else                   valB = r_regs[srcB];
        end
    end

endmodule

// File: tb/tb_y86_regfile_sb.sv
// Bench for y86_regfile_sb: directed scenarios plus a randomized run checked
// against an array/integer model of registers and pending counts.
module tb_y86_regfile_sb;

    localparam int DATA_W   = 64;
    localparam int NREGS    = 15;
    localparam int IDX_W    = 4;
    localparam int PEND_W   = 2;
    localparam int PEND_MAX = (1 << PEND_W) - 1;
    localparam logic [IDX_W-1:0] RN = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic [IDX_W-1:0]  srcA, srcB, iss_dstE, iss_dstM, dstE, dstM;
    logic [DATA_W-1:0] valA, valB, valE, valM;
    logic              rdyA, rdyB, iss_valid, iss_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] m_regs [NREGS];
    int                m_pend [NREGS];

    always #5 clk = ~clk;

    y86_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .srcA      (srcA),
        .srcB      (srcB),
        .valA      (valA),
        .valB      (valB),
        .rdyA      (rdyA),
        .rdyB      (rdyB),
        .iss_valid (iss_valid),
        .iss_dstE  (iss_dstE),
        .iss_dstM  (iss_dstM),
        .iss_ready (iss_ready),
        .dstE      (dstE),
        .valE      (valE),
        .dstM      (dstM),
        .valM      (valM)
    );

    // ---------------- reference model ----------------
    function automatic bit m_dec(int r);
        return (int'(dstE) == r) || (int'(dstM) == r);
    endfunction

    function automatic logic [DATA_W-1:0] m_val(logic [IDX_W-1:0] s);
        if (int'(s) >= NREGS) return '0;
        if (s == dstM) return valM;
        if (s == dstE) return valE;
        return m_regs[s];
    endfunction

    function automatic bit m_rdy(logic [IDX_W-1:0] s);
        if (int'(s) >= NREGS) return 1'b1;
        return (m_pend[s] == 0) || (m_pend[s] == 1 && m_dec(int'(s)));
    endfunction

    function automatic bit m_iss_ready();
        if (!iss_valid) return 1'b1;
        if (int'(iss_dstE) < NREGS && m_pend[iss_dstE] == PEND_MAX && !m_dec(int'(iss_dstE))) return 1'b0;
        if (int'(iss_dstM) < NREGS && m_pend[iss_dstM] == PEND_MAX && !m_dec(int'(iss_dstM))) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_commit();
        bit ir;
        bit inc;
        bit dec;
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = (r == 4) ? 64'h0000_0000_0000_FFF8 : '0;
                m_pend[r] = 0;
            end
        end else begin
            ir = m_iss_ready();
            for (int r = 0; r < NREGS; r++) begin
                inc = iss_valid && ir && (int'(iss_dstE) == r || int'(iss_dstM) == r);
                dec = m_dec(r);
                if (inc && !dec) m_pend[r] = m_pend[r] + 1;
                else if (dec && !inc && m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
            end
            if (int'(dstE) < NREGS) m_regs[dstE] = valE;
            if (int'(dstM) < NREGS) m_regs[dstM] = valM;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        srcA = '0; srcB = '0;
        iss_valid = 1'b0; iss_dstE = RN; iss_dstM = RN;
        dstE = RN; dstM = RN; valE = '0; valM = '0;
    endtask

    // Inputs are set after a negedge; the model absorbs the cycle, then the edge fires.
    task automatic tick();
        model_commit();
        @(posedge clk);
        @(negedge clk);
        set_idle();
    endtask

    task automatic issue(logic [IDX_W-1:0] de, logic [IDX_W-1:0] dm);
        iss_valid = 1'b1; iss_dstE = de; iss_dstM = dm;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;
        srcA = 4'd4; srcB = 4'd0;
        #1;
        n_tests++; if (valA !== 64'hFFF8) begin n_fail++; $display("FAIL reset_valA got %h exp %h", valA, 64'hFFF8); end
        n_tests++; if (valB !== 64'h0) begin n_fail++; $display("FAIL reset_valB got %h exp 0", valB); end
        n_tests++; if (rdyA !== 1'b1 || rdyB !== 1'b1) begin n_fail++; $display("FAIL reset_rdy got %b%b exp 11", rdyA, rdyB); end
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready got %b exp 1", iss_ready); end
        for (int r = 0; r < 16; r++) begin
            srcB = 4'(r);
            #1;
            n_tests++;
            if (valB !== ((r == 4) ? 64'hFFF8 : 64'h0)) begin
                n_fail++; $display("FAIL reset_reg%0d got %h", r, valB);
            end
        end
        tick();
    endtask

    task automatic test_write_bypass();
        issue(4'd3, RN);
        #1;
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL wb_issue got %b exp 1", iss_ready); end
        tick();
        srcA = 4'd3;
        #1;
        n_tests++; if (rdyA !== 1'b0) begin n_fail++; $display("FAIL wb_pending_rdy got %b exp 0", rdyA); end
        dstE = 4'd3; valE = 64'h1234;
        #1;
        n_tests++; if (valA !== 64'h1234) begin n_fail++; $display("FAIL wb_bypass got %h exp 1234", valA); end
        n_tests++; if (rdyA !== 1'b1) begin n_fail++; $display("FAIL wb_bypass_rdy got %b exp 1", rdyA); end
        tick();
        srcA = 4'd3;
        #1;
        n_tests++; if (valA !== 64'h1234) begin n_fail++; $display("FAIL wb_array got %h exp 1234", valA); end
        n_tests++; if (rdyA !== 1'b1) begin n_fail++; $display("FAIL wb_array_rdy got %b exp 1", rdyA); end
    endtask

    task automatic test_collision();
        issue(4'd4, 4'd4);
        tick();
        srcA = 4'd4;
        dstE = 4'd4; valE = 64'h10;
        dstM = 4'd4; valM = 64'h20;
        #1;
        n_tests++; if (valA !== 64'h20) begin n_fail++; $display("FAIL coll_bypass got %h exp 20", valA); end
        n_tests++; if (rdyA !== 1'b1) begin n_fail++; $display("FAIL coll_rdy got %b exp 1", rdyA); end
        tick();
        srcA = 4'd4;
        #1;
        n_tests++; if (valA !== 64'h20) begin n_fail++; $display("FAIL coll_array got %h exp 20", valA); end
        n_tests++; if (rdyA !== 1'b1) begin n_fail++; $display("FAIL coll_count_once got %b exp 1", rdyA); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            issue(4'd2, RN);
            #1;
            n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue%0d got %b exp 1", k, iss_ready); end
            tick();
        end
        srcA = 4'd2;
        #1;
        n_tests++; if (rdyA !== 1'b0) begin n_fail++; $display("FAIL sat_rdy got %b exp 0", rdyA); end
        issue(4'd2, RN);
        #1;
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL sat_full got %b exp 0", iss_ready); end
        tick();
        issue(4'd2, RN);
        dstE = 4'd2; valE = 64'hAB;
        #1;
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue_with_wb got %b exp 1", iss_ready); end
        tick();
        issue(RN, 4'd2);
        #1;
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL sat_still3 got %b exp 0", iss_ready); end
        for (int k = 0; k < 3; k++) begin
            set_idle();
            srcA = 4'd2; dstM = 4'd2; valM = 64'(k + 1);
            #1;
            n_tests++;
            if (rdyA !== (k == 2)) begin n_fail++; $display("FAIL sat_drain%0d got %b exp %b", k, rdyA, k == 2); end
            tick();
        end
        srcA = 4'd2;
        #1;
        n_tests++; if (rdyA !== 1'b1 || valA !== 64'd3) begin n_fail++; $display("FAIL sat_empty got %b/%h exp 1/3", rdyA, valA); end
    endtask

    task automatic test_ready_bypass();
        issue(4'd5, RN);
        tick();
        srcB = 4'd5;
        #1;
        n_tests++; if (rdyB !== 1'b0) begin n_fail++; $display("FAIL rb_pending got %b exp 0", rdyB); end
        dstE = 4'd5; valE = 64'h77;
        #1;
        n_tests++; if (rdyB !== 1'b1 || valB !== 64'h77) begin n_fail++; $display("FAIL rb_bypass got %b/%h exp 1/77", rdyB, valB); end
        tick();
        srcB = 4'd5;
        #1;
        n_tests++; if (rdyB !== 1'b1) begin n_fail++; $display("FAIL rb_cleared got %b exp 1", rdyB); end
    endtask

    task automatic test_reset_midflight();
        issue(4'd6, RN);
        tick();
        srcA = 4'd6;
        #1;
        n_tests++; if (rdyA !== 1'b0) begin n_fail++; $display("FAIL rm_pending got %b exp 0", rdyA); end
        rst = 1'b1;
        issue(RN, 4'd7);
        dstE = 4'd6; valE = 64'hDEAD;
        tick();
        rst = 1'b0;
        srcA = 4'd6; srcB = 4'd7;
        #1;
        n_tests++; if (rdyA !== 1'b1 || rdyB !== 1'b1) begin n_fail++; $display("FAIL rm_rdy got %b%b exp 11", rdyA, rdyB); end
        n_tests++; if (valA !== 64'h0) begin n_fail++; $display("FAIL rm_reg6 got %h exp 0", valA); end
        srcB = 4'd4;
        #1;
        n_tests++; if (valB !== 64'hFFF8) begin n_fail++; $display("FAIL rm_sp got %h exp fff8", valB); end
    endtask

    function automatic logic [IDX_W-1:0] pick_wb();
        int r;
        r = $urandom_range(0, NREGS - 1);
        if (m_pend[r] > 0 && $urandom_range(0, 2) != 0) return IDX_W'(r);
        return RN;
    endfunction

    task automatic test_random();
        logic [DATA_W-1:0] ev;
        for (int c = 0; c < 500; c++) begin
            srcA = IDX_W'($urandom_range(0, 15));
            srcB = IDX_W'($urandom_range(0, 15));
            iss_valid = 1'($urandom_range(0, 1));
            iss_dstE = ($urandom_range(0, 3) == 0) ? RN : IDX_W'($urandom_range(0, 14));
            iss_dstM = ($urandom_range(0, 1) == 0) ? RN : IDX_W'($urandom_range(0, 14));
            dstE = pick_wb();
            dstM = pick_wb();
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            #1;
            ev = m_val(srcA);
            n_tests++; if (valA !== ev) begin n_fail++; $display("FAIL rnd_valA c%0d got %h exp %h", c, valA, ev); end
            ev = m_val(srcB);
            n_tests++; if (valB !== ev) begin n_fail++; $display("FAIL rnd_valB c%0d got %h exp %h", c, valB, ev); end
            n_tests++; if (rdyA !== m_rdy(srcA)) begin n_fail++; $display("FAIL rnd_rdyA c%0d got %b exp %b", c, rdyA, m_rdy(srcA)); end
            n_tests++; if (rdyB !== m_rdy(srcB)) begin n_fail++; $display("FAIL rnd_rdyB c%0d got %b exp %b", c, rdyB, m_rdy(srcB)); end
            n_tests++; if (iss_ready !== m_iss_ready()) begin n_fail++; $display("FAIL rnd_iss_ready c%0d got %b exp %b", c, iss_ready, m_iss_ready()); end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        @(negedge clk);
        test_reset();
        test_write_bypass();
        test_collision();
        test_saturate();
        test_ready_bypass();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
